pes_se_acc: RTL and testbench
=============================

# pes_se_acc

Batch accumulator placed directly downstream of the `pes_se_M` 4x4 multiplier. It accepts 8-bit products over a valid/ready handshake and sums a batch of N products, or fewer if the batch is flushed early. It then presents the sum, the term count and an overflow flag over a second valid/ready handshake. This turns the combinational multiplier into a dot-product / multiply-accumulate datapath.

## Interface
Parameters:
- `PROD_W`, 8: product width; matches the `pes_se_M` `product` output.
- `N`, 4: products per full batch; N ≥ 1.
- `ACC_W`, 10: accumulator width; must be ≥ PROD_W.
- `CNT_W`, 3: term-count width; must hold N.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `prod`  in  PROD_W  unsigned product from `pes_se_M`
- `prod_valid`  in  1  `prod` is valid this cycle
- `prod_ready`  out  1  block can accept `prod` this cycle
- `flush`  in  1  close the current batch early
- `sum`  out  ACC_W  accumulated batch result
- `cnt`  out  CNT_W  number of products in `sum`
- `ovf`  out  1  the batch exceeded the range of ACC_W
- `sum_valid`  out  1  `sum`, `cnt` and `ovf` are valid
- `sum_ready`  in  1  downstream accepts the result

## Operation
- A beat is accepted when `prod_valid` and `prod_ready` are both high. A result is taken when `sum_valid` and `sum_ready` are both high.
- States: IDLE, ACCUM, HOLD.
- IDLE: acc=0, cnt=0, ovf=0, `prod_ready`=1, `sum_valid`=0.
  - On an accepted beat: acc=prod and cnt=1. Go to HOLD if N==1 or `flush` is high, otherwise go to ACCUM.
  - `flush` with no accepted beat is ignored, so empty batches are never emitted.
- ACCUM: `prod_ready`=1.
  - On an accepted beat: acc=acc+prod and cnt=cnt+1.
  - Go to HOLD when the new cnt equals N, or when `flush` is high. If `flush` arrives in the same cycle as an accepted beat, that beat is included in the sum.
- HOLD: `prod_ready`=0, `sum_valid`=1. `sum`, `cnt` and `ovf` are stable until taken. When taken, go to IDLE and clear acc, cnt and ovf. `flush` is ignored in HOLD.
- Arithmetic is unsigned, with an ACC_W+1-bit internal add. A carry out of ACC_W sets `ovf`, which stays set until the result is taken. What `sum` holds after an overflow depends on the configuration (see Configuration).
- Outputs are registered; `sum` equals acc and `cnt` equals the count register in every state.

## Timing
- Reset values: `sum`=0, `cnt`=0, `ovf`=0, `sum_valid`=0, `prod_ready`=1, state=IDLE.
- `rst` wins over every other input in the same cycle. Reset in mid-batch or in HOLD discards the partial or pending result with no output.
- Latency: `sum_valid` rises in the cycle after the final beat (the Nth beat, or the flushed beat) is accepted.
- Throughput: a full batch takes N accept cycles, at least 1 HOLD cycle, then IDLE. The first beat of the next batch can be accepted in the cycle after the result is taken, so there is one bubble per batch.
- `prod_ready` is a function of state only and does not depend combinationally on `prod_valid`. `sum_valid` does not depend on `sum_ready`.
- Backpressure: with `sum_ready` held low, HOLD persists indefinitely and `prod_ready` stays 0.

## Configuration
- `PES_SE_ACC_SAT_EN` defined: on overflow, acc saturates to 2^ACC_W−1 and stays there for the rest of the batch; `ovf`=1.
- Not defined: acc wraps modulo 2^ACC_W; `ovf`=1.
- Behaviour without overflow is identical in both builds.

## Test plan
- Reset, then a full batch of the products 64, 1, 4, 0, each beat with `prod_valid`=1 on consecutive cycles and `sum_ready`=1 → `sum_valid` high one cycle after the 4th beat, with `sum`=69, `cnt`=4, `ovf`=0. The state returns to IDLE next cycle, with `prod_ready`=1.
- Flush: beats 225 then 10, with `flush` high alongside the 10 → `sum`=235, `cnt`=2. A `flush` pulse in IDLE with no beat produces no `sum_valid`.
- Backpressure: complete a batch with `sum_ready`=0 for 5 cycles → `sum_valid`, `sum` and `cnt` stay stable and `prod_ready`=0 throughout, and beats offered during that time are not accepted. Raising `sum_ready` completes the handoff in one cycle.
- Overflow with ACC_W=8 and N=4, beats 200, 100, 0, 0 → `ovf`=1. `sum`=44 without `PES_SE_ACC_SAT_EN`; `sum`=255 with it.
- Reset mid-batch: after beats 64 and 1, assert `rst` for one cycle → no `sum_valid`. The next batch 4, 4, 4, 4 gives `sum`=16, `cnt`=4.
- N=1 parameterisation: each accepted beat of 9 → `sum`=9, `cnt`=1 on the next cycle. Continuous `prod_valid` is accepted only on alternate cycles.

Source files
------------

// File: rtl/pes_se_acc.sv
// Batch accumulator behind the pes_se_M multiplier: sums up to N products per batch and hands the result downstream.
// Optional build macro PES_SE_ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module pes_se_acc #(
   parameter int PROD_W = 8,
   parameter int N      = 4,
   parameter int ACC_W  = 10,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic              flush,
   output logic [ACC_W-1:0]  sum,
   output logic [CNT_W-1:0]  cnt,
   output logic              ovf,
   output logic              sum_valid,
   input  logic              sum_ready
);

   // state   | meaning
   // S_IDLE  | empty batch, waiting for the first product
   // S_ACCUM | batch open, adding products until N terms or flush
   // S_HOLD  | result presented, waiting for downstream to take it
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

   state_t             state_q;
   state_t             state_d;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;
   logic               accept;
   logic               take;
   logic [ACC_W:0]     add_ext;
   logic               carry;
   logic [ACC_W-1:0]   acc_next;
   logic [CNT_W-1:0]   cnt_inc;

   assign accept  = prod_valid & prod_ready;
   assign take    = sum_valid & sum_ready;
   assign add_ext = {1'b0, acc_q} + (ACC_W+1)'(prod);
   assign carry   = add_ext[ACC_W];
   assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef PES_SE_ACC_SAT_EN
   // Once saturated, the batch stays pinned at full scale until it is taken.
   assign acc_next = (carry | ovf_q) ? {ACC_W{1'b1}} : add_ext[ACC_W-1:0];
`else
   assign acc_next = add_ext[ACC_W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = ((N == 1) || flush) ? S_HOLD : S_ACCUM;
            end
         end
         S_ACCUM: begin
            // A flush without a beat still closes a batch that holds at least one term.
            if (flush || (accept && (cnt_inc == CNT_W'(N)))) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (take) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      prod_ready = 1'b1;
      sum_valid  = 1'b0;
      if (state_q == S_HOLD) begin
         prod_ready = 1'b0;
         sum_valid  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  acc_q <= ACC_W'(prod);
                  cnt_q <= CNT_W'(1);
                  ovf_q <= 1'b0;
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  acc_q <= acc_next;
                  cnt_q <= cnt_inc;
                  ovf_q <= ovf_q | carry;
               end
            end
            S_HOLD: begin
               if (take) begin
                  acc_q <= '0;
                  cnt_q <= '0;
                  ovf_q <= 1'b0;
               end
            end
            default: begin
               acc_q <= '0;
               cnt_q <= '0;
               ovf_q <= 1'b0;
            end
         endcase
      end
   end

   assign sum = acc_q;
   assign cnt = cnt_q;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_pes_se_acc.sv
// Directed bench for pes_se_acc: default, ACC_W=8 overflow and N=1 instances.
module tb_pes_se_acc;

`ifdef PES_SE_ACC_SAT_EN
   localparam logic [31:0] OVF_SUM = 32'd255;
`else
   localparam logic [31:0] OVF_SUM = 32'd44;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [7:0] prod0 = '0;
   logic       pv0 = 1'b0, fl0 = 1'b0, sr0 = 1'b0;
   logic [9:0] sum0;
   logic [2:0] cnt0;
   logic       ovf0, sv0, pr0;

   logic [7:0] prod8 = '0;
   logic       pv8 = 1'b0, fl8 = 1'b0, sr8 = 1'b0;
   logic [7:0] sum8;
   logic [2:0] cnt8;
   logic       ovf8, sv8, pr8;

   logic [7:0] prod1 = '0;
   logic       pv1 = 1'b0, fl1 = 1'b0, sr1 = 1'b0;
   logic [9:0] sum1;
   logic [2:0] cnt1;
   logic       ovf1, sv1, pr1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pes_se_acc #(.PROD_W(8), .N(4), .ACC_W(10), .CNT_W(3)) dut0 (
      .clk(clk), .rst(rst), .prod(prod0), .prod_valid(pv0), .prod_ready(pr0), .flush(fl0),
      .sum(sum0), .cnt(cnt0), .ovf(ovf0), .sum_valid(sv0), .sum_ready(sr0));

   pes_se_acc #(.PROD_W(8), .N(4), .ACC_W(8), .CNT_W(3)) dut8 (
      .clk(clk), .rst(rst), .prod(prod8), .prod_valid(pv8), .prod_ready(pr8), .flush(fl8),
      .sum(sum8), .cnt(cnt8), .ovf(ovf8), .sum_valid(sv8), .sum_ready(sr8));

   pes_se_acc #(.PROD_W(8), .N(1), .ACC_W(10), .CNT_W(3)) dut1 (
      .clk(clk), .rst(rst), .prod(prod1), .prod_valid(pv1), .prod_ready(pr1), .flush(fl1),
      .sum(sum1), .cnt(cnt1), .ovf(ovf1), .sum_valid(sv1), .sum_ready(sr1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic beat0(input logic [7:0] p, input logic f);
      prod0 = p;
      pv0   = 1'b1;
      fl0   = f;
      tick();
      pv0   = 1'b0;
      fl0   = 1'b0;
   endtask

   task automatic chk0(input string tag, input logic sv, input logic [9:0] s,
                       input logic [2:0] c, input logic o, input logic pr);
      chk({tag, ".sum_valid"}, 32'(sv0), 32'(sv));
      chk({tag, ".sum"},       32'(sum0), 32'(s));
      chk({tag, ".cnt"},       32'(cnt0), 32'(c));
      chk({tag, ".ovf"},       32'(ovf0), 32'(o));
      chk({tag, ".prod_ready"},32'(pr0), 32'(pr));
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk0("reset", 1'b0, 10'd0, 3'd0, 1'b0, 1'b1);
      chk("reset8.prod_ready", 32'(pr8), 32'd1);
      chk("reset1.sum_valid",  32'(sv1), 32'd0);

      // full batch 64,1,4,0
      sr0 = 1'b1;
      beat0(8'd64, 1'b0);
      beat0(8'd1, 1'b0);
      beat0(8'd4, 1'b0);
      chk0("batch_b3", 1'b0, 10'd69, 3'd3, 1'b0, 1'b1);
      beat0(8'd0, 1'b0);
      chk0("batch_hold", 1'b1, 10'd69, 3'd4, 1'b0, 1'b0);
      tick();
      chk0("batch_idle", 1'b0, 10'd0, 3'd0, 1'b0, 1'b1);

      // early flush with the closing beat
      sr0 = 1'b0;
      beat0(8'd225, 1'b0);
      beat0(8'd10, 1'b1);
      chk0("flush_hold", 1'b1, 10'd235, 3'd2, 1'b0, 1'b0);
      sr0 = 1'b1;
      tick();
      chk0("flush_taken", 1'b0, 10'd0, 3'd0, 1'b0, 1'b1);
      fl0 = 1'b1;
      tick();
      fl0 = 1'b0;
      chk0("flush_empty", 1'b0, 10'd0, 3'd0, 1'b0, 1'b1);
      tick();
      chk("flush_empty2.sum_valid", 32'(sv0), 32'd0);

      // flush without a beat in ACCUM closes the batch
      sr0 = 1'b0;
      beat0(8'd7, 1'b0);
      fl0 = 1'b1;
      tick();
      fl0 = 1'b0;
      chk0("flush_nobeat", 1'b1, 10'd7, 3'd1, 1'b0, 1'b0);
      sr0 = 1'b1;
      tick();
      chk("flush_nobeat_taken.sum_valid", 32'(sv0), 32'd0);

      // backpressure: 1+2+3+4 held for 5 cycles while beats are offered
      sr0 = 1'b0;
      beat0(8'd1, 1'b0);
      beat0(8'd2, 1'b0);
      beat0(8'd3, 1'b0);
      beat0(8'd4, 1'b0);
      for (int i = 0; i < 5; i++) begin
         prod0 = 8'd99;
         pv0   = 1'b1;
         fl0   = 1'b1;
         tick();
         chk0("bp_hold", 1'b1, 10'd10, 3'd4, 1'b0, 1'b0);
      end
      pv0 = 1'b0;
      fl0 = 1'b0;
      sr0 = 1'b1;
      tick();
      chk0("bp_taken", 1'b0, 10'd0, 3'd0, 1'b0, 1'b1);

      // reset in mid-batch discards the partial result
      sr0 = 1'b0;
      beat0(8'd64, 1'b0);
      beat0(8'd1, 1'b0);
      rst = 1'b1;
      prod0 = 8'd50;
      pv0 = 1'b1;
      tick();
      rst = 1'b0;
      pv0 = 1'b0;
      chk0("rst_mid", 1'b0, 10'd0, 3'd0, 1'b0, 1'b1);
      beat0(8'd4, 1'b0);
      beat0(8'd4, 1'b0);
      beat0(8'd4, 1'b0);
      beat0(8'd4, 1'b0);
      chk0("after_rst", 1'b1, 10'd16, 3'd4, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk0("rst_hold", 1'b0, 10'd0, 3'd0, 1'b0, 1'b1);

      // overflow on ACC_W=8: 200+100 carries out
      sr8 = 1'b0;
      pv8 = 1'b1;
      prod8 = 8'd200;
      tick();
      chk("ovf_b1.ovf", 32'(ovf8), 32'd0);
      prod8 = 8'd100;
      tick();
      chk("ovf_b2.ovf", 32'(ovf8), 32'd1);
      chk("ovf_b2.sum", 32'(sum8), OVF_SUM);
      prod8 = 8'd0;
      tick();
      tick();
      pv8 = 1'b0;
      chk("ovf_hold.sum_valid", 32'(sv8), 32'd1);
      chk("ovf_hold.sum", 32'(sum8), OVF_SUM);
      chk("ovf_hold.cnt", 32'(cnt8), 32'd4);
      chk("ovf_hold.ovf", 32'(ovf8), 32'd1);
      sr8 = 1'b1;
      tick();
      chk("ovf_taken.ovf", 32'(ovf8), 32'd0);
      chk("ovf_taken.sum_valid", 32'(sv8), 32'd0);

      // N=1: continuous valid accepted on alternate cycles
      sr1 = 1'b1;
      prod1 = 8'd9;
      pv1 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("n1_hold.sum_valid", 32'(sv1), 32'd1);
         chk("n1_hold.sum", 32'(sum1), 32'd9);
         chk("n1_hold.cnt", 32'(cnt1), 32'd1);
         chk("n1_hold.prod_ready", 32'(pr1), 32'd0);
         tick();
         chk("n1_idle.sum_valid", 32'(sv1), 32'd0);
         chk("n1_idle.prod_ready", 32'(pr1), 32'd1);
      end
      pv1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
